exu_alu_mdu: RTL and testbench
==============================

Name: exu_alu_mdu

Overview:
- Parametrised execute-stage unit for the MIPS pipeline. Combines the EX forwarding muxes, an extended single-cycle ALU and an iterative multiply/divide unit with HI/LO registers.
- Registers its result into the EX/MEM boundary one cycle after issue.
- Asserts stall while a multi-cycle operation runs, so hazard control can freeze IF/ID/EX.

Parameters:
- WIDTH, 32, datapath width in bits; must be a power of two, 8 or greater.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  kill the op in EX, including any in-flight mul/div
- in_valid  in  1  op present in ID/EX
- alu_control  in  4  operation select
- alu_src  in  1  1: operand B = imm, only when forward_b = 00
- rs_data  in  WIDTH  ID/EX rs value
- rt_data  in  WIDTH  ID/EX rt value
- imm  in  WIDTH  sign-extended immediate
- forward_a  in  2  00 rs_data, 01 wb_data, 10 exmem_data, 11 treated as 00
- forward_b  in  2  same encoding; 00 selects imm or rt_data per alu_src
- wb_data  in  WIDTH  MEM/WB writeback value
- exmem_data  in  WIDTH  EX/MEM ALU result
- stall  out  1  combinational; high while mul/div busy, or on the issue cycle of mul/div
- out_valid  out  1  registered result valid
- result  out  WIDTH  registered result
- zero  out  1  registered; 1 when result == 0 and out_valid
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Operands: A = fwdA mux. B = fwdB mux, with imm substituted only on path 00.
- Single-cycle ops (A op B):
  - 0000 AND; 0001 OR; 0011 XOR; 1100 NOR
  - 0010 ADD; 0110 SUB, both wrap mod 2^WIDTH, no overflow trap
  - 0111 SLT signed (result 1 or 0)
  - 1001 SLL: B << A[SHW-1:0]; 1010 SRL: B >> A[SHW-1:0]; 1011 SRA: arithmetic right shift by the same amount
  - 1101 MFHI: result = hi; 1110 MFLO: result = lo
  - Any other code: result 0
- Single-cycle latency: in_valid at edge N gives result/out_valid valid after edge N+1. out_valid is low in cycles with no valid issue.
- 0100 MULTU: unsigned shift-add, one bit per cycle.
- 0101 DIVU: restoring division, one bit per cycle. Not present without EXU_DIV_EN.
- FSM states and transitions:
  - IDLE -> RUN on accepted in_valid with a mul/div code; counter loaded with WIDTH-1, operands latched.
  - RUN: counter decrements each cycle; RUN -> DONE when counter reaches 0.
  - DONE: write hi/lo, pulse out_valid with result = lo; DONE -> IDLE.
- Total latency is WIDTH+1 cycles from issue to out_valid.
- stall is high from the issue cycle through the RUN cycles and is low in DONE. Upstream holds ID/EX stable while stalled; the unit ignores in_valid outside IDLE.
- MULTU: {hi,lo} = A*B, full 2*WIDTH-bit product.
- DIVU: lo = quotient, hi = remainder. Divide by zero gives lo = all ones, hi = A; no trap.
- MFHI/MFLO issued in the cycle after DONE see the new hi/lo values.
- flush: out_valid is 0 next cycle. If in RUN, the FSM returns to IDLE, hi/lo are unchanged and stall drops the next cycle. flush takes priority over in_valid.
- Reset: result 0, zero 0, out_valid 0, hi 0, lo 0, FSM IDLE, stall 0. Reset during RUN aborts at the next edge.

Optional Feature:
- Macro EXU_DIV_EN.
- Defined: DIVU is available as specified above.
- Undefined: no divider logic is built. Code 0101 behaves as a single-cycle op with result 0; hi/lo are unchanged and there is no stall.

Test Plan:
- ADD, fwd 00/00, rs=7, rt=5 -> next cycle result=12, zero=0, out_valid=1. SUB with the same operands (rs=7, rt=5) -> result=2.
- SUB, forward_a=10 with exmem_data=9, forward_b=01 with wb_data=9 -> result=0, zero=1. forward_a=11 -> rs_data is used.
- SLT, A=0xFFFFFFFF, B=1 -> result=1. SRA of 0x80000000 by 4 -> 0xF8000000. SLL, A=36 -> shift by 4.
- MULTU 0xFFFFFFFF * 2 -> stall high for 32 cycles, out_valid on cycle 33, hi=1, lo=0xFFFFFFFE. Then MFHI -> result=1.
- DIVU 100/7 -> lo=14, hi=2. DIVU 5/0 -> lo=0xFFFFFFFF, hi=5. With EXU_DIV_EN undefined: DIVU -> result 0, no stall.
- Flush at cycle 10 of MULTU -> stall low next cycle, hi/lo keep prior values, out_valid never asserted. rst mid-RUN -> all outputs 0.

Source files
------------

// File: rtl/exu_alu_mdu.sv
// exu_alu_mdu -- MIPS execute stage: forwarding muxes, single-cycle ALU and
// an iterative multiply/divide unit that owns the HI/LO registers.
//
// Optional feature: define EXU_DIV_EN to build the restoring divider (DIVU).
// Without it, code 0101 is a single-cycle op with result 0.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   flush             kills the op in EX, including an in-flight mul/div
//   in_valid          op present in ID/EX
//   alu_control[3:0]  operation select
//   alu_src           operand B = imm (only on forward_b path 00)
//   rs_data, rt_data  ID/EX register operands
//   imm               sign-extended immediate
//   forward_a/b[1:0]  00 register, 01 wb_data, 10 exmem_data, 11 as 00
//   wb_data           MEM/WB writeback value
//   exmem_data        EX/MEM ALU result
//   stall             combinational: issue cycle of mul/div and all RUN cycles
//   out_valid         registered result valid (one-cycle pulse per op)
//   result, zero      registered result and result==0 flag
//   hi, lo            HI/LO registers
//
// Handshake: an op is accepted when in_valid is high, flush is low and the
// FSM is IDLE. Upstream holds ID/EX stable while stall is high; in_valid is
// ignored in RUN and DONE. Each accepted op produces exactly one out_valid
// pulse unless flushed or reset.
module exu_alu_mdu #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [3:0]       alu_control,
  input  logic             alu_src,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic [WIDTH-1:0] imm,
  input  logic [1:0]       forward_a,
  input  logic [1:0]       forward_b,
  input  logic [WIDTH-1:0] wb_data,
  input  logic [WIDTH-1:0] exmem_data,
  output logic             stall,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_MULTU = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1001;
  localparam logic [3:0] OP_SRL   = 4'b1010;
  localparam logic [3:0] OP_SRA   = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MFHI  = 4'b1101;
  localparam logic [3:0] OP_MFLO  = 4'b1110;
`ifdef EXU_DIV_EN
  localparam logic [3:0] OP_DIVU  = 4'b0101;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [SHW-1:0]     cnt_q;
  logic [2*WIDTH-1:0] acc_q;    // mul: {partial hi, multiplier/lo}; div: {rem, dividend/quotient}
  logic [WIDTH-1:0]   opd_q;    // multiplicand or divisor
  logic [WIDTH-1:0]   op_a, op_b, alu_out;
  logic [SHW-1:0]     shamt;
  logic               is_md, accept, start_md, last_step;
  logic [2*WIDTH-1:0] step_acc, step_nxt;
  logic [WIDTH-1:0]   step_opd;
  logic [WIDTH:0]     mul_sum;
`ifdef EXU_DIV_EN
  logic               div_q, step_div, div_ge;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH-1:0]   div_rem;
`endif

  // Forwarding muxes; imm only replaces rt_data on the non-forwarded path.
  always_comb begin
    case (forward_a)
      2'b01:   op_a = wb_data;
      2'b10:   op_a = exmem_data;
      default: op_a = rs_data;
    endcase
    case (forward_b)
      2'b01:   op_b = wb_data;
      2'b10:   op_b = exmem_data;
      default: op_b = alu_src ? imm : rt_data;
    endcase
  end

  assign shamt = op_a[SHW-1:0];

  always_comb begin
    alu_out = '0;
    case (alu_control)
      OP_AND:  alu_out = op_a & op_b;
      OP_OR:   alu_out = op_a | op_b;
      OP_XOR:  alu_out = op_a ^ op_b;
      OP_NOR:  alu_out = ~(op_a | op_b);
      OP_ADD:  alu_out = op_a + op_b;
      OP_SUB:  alu_out = op_a - op_b;
      OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLL:  alu_out = op_b << shamt;
      OP_SRL:  alu_out = op_b >> shamt;
      OP_SRA:  alu_out = $signed(op_b) >>> shamt;
      OP_MFHI: alu_out = hi;
      OP_MFLO: alu_out = lo;
      default: alu_out = '0;
    endcase
  end

`ifdef EXU_DIV_EN
  assign is_md = (alu_control == OP_MULTU) || (alu_control == OP_DIVU);
`else
  assign is_md = (alu_control == OP_MULTU);
`endif
  assign accept    = (state_q == IDLE) && in_valid && !flush;
  assign start_md  = accept && is_md;
  assign last_step = (state_q == RUN) && (cnt_q == SHW'(1));
  assign stall     = start_md || (state_q == RUN);

  // One iteration of shift-add / restoring division. The first iteration runs
  // on the issue edge straight from the operands, so WIDTH iterations fit in
  // the issue edge plus WIDTH-1 RUN edges.
  always_comb begin
    step_acc = acc_q;
    step_opd = opd_q;
`ifdef EXU_DIV_EN
    step_div = div_q;
`endif
    if (state_q == IDLE) begin
      step_acc = {{WIDTH{1'b0}}, op_b};
      step_opd = op_a;
`ifdef EXU_DIV_EN
      step_div = (alu_control == OP_DIVU);
      if (alu_control == OP_DIVU) begin
        step_acc = {{WIDTH{1'b0}}, op_a};
        step_opd = op_b;
      end
`endif
    end
    mul_sum  = {1'b0, step_acc[2*WIDTH-1:WIDTH]} + (step_acc[0] ? {1'b0, step_opd} : '0);
    step_nxt = {mul_sum, step_acc[WIDTH-1:1]};
`ifdef EXU_DIV_EN
    // Remainder always fits WIDTH bits after the subtract decision, so the
    // subtraction can be done modulo 2^WIDTH. Divisor 0 yields all-ones
    // quotient and remainder = dividend without special casing.
    div_trial = {step_acc[2*WIDTH-1:WIDTH], step_acc[WIDTH-1]};
    div_ge    = div_trial >= {1'b0, step_opd};
    div_rem   = div_ge ? (div_trial[WIDTH-1:0] - step_opd) : div_trial[WIDTH-1:0];
    if (step_div) step_nxt = {div_rem, step_acc[WIDTH-2:0], div_ge};
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_md) state_d = RUN;
      RUN:     if (cnt_q == SHW'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      acc_q <= '0;
      opd_q <= '0;
`ifdef EXU_DIV_EN
      div_q <= 1'b0;
`endif
    end else if (start_md) begin
      cnt_q <= SHW'(WIDTH - 1);
      acc_q <= step_nxt;
      opd_q <= step_opd;
`ifdef EXU_DIV_EN
      div_q <= step_div;
`endif
    end else if (state_q == RUN) begin
      cnt_q <= cnt_q - SHW'(1);
      acc_q <= step_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      out_valid <= 1'b0;
      zero      <= 1'b0;
      if (!flush) begin
        if (last_step) begin
          hi        <= step_nxt[2*WIDTH-1:WIDTH];
          lo        <= step_nxt[WIDTH-1:0];
          result    <= step_nxt[WIDTH-1:0];
          zero      <= (step_nxt[WIDTH-1:0] == '0);
          out_valid <= 1'b1;
        end else if (accept && !is_md) begin
          result    <= alu_out;
          zero      <= (alu_out == '0);
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_exu_alu_mdu.sv
// Testbench for exu_alu_mdu: directed vectors with hand-computed results.
// The driver pushes each expected response into exp_q at issue; the monitor
// pops and compares whenever out_valid is seen.
module tb_exu_alu_mdu;

  localparam int W = 32;

  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011, OP_MULTU = 4'b0100, OP_DIVU = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_BAD = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1001, OP_SRL = 4'b1010, OP_SRA = 4'b1011;
  localparam logic [3:0] OP_NOR = 4'b1100, OP_MFHI = 4'b1101, OP_MFLO = 4'b1110;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic [3:0]   alu_control = '0;
  logic         alu_src = 1'b0;
  logic [W-1:0] rs_data = '0, rt_data = '0, imm = '0, wb_data = '0, exmem_data = '0;
  logic [1:0]   forward_a = '0, forward_b = '0;
  logic         stall, out_valid, zero;
  logic [W-1:0] result, hi, lo;

  typedef struct packed {
    logic [W-1:0] res;
    logic         chk_hl;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] hl_hi, hl_lo;

  exu_alu_mdu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .alu_control(alu_control), .alu_src(alu_src),
    .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
    .forward_a(forward_a), .forward_b(forward_b),
    .wb_data(wb_data), .exmem_data(exmem_data),
    .stall(stall), .out_valid(out_valid), .result(result), .zero(zero),
    .hi(hi), .lo(lo)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got result %h expected no output", result);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", result, mon_e.res);
        check("zero", {31'b0, zero}, {31'b0, (mon_e.res == '0)});
        if (mon_e.chk_hl) begin
          check("hi", hi, mon_e.hi);
          check("lo", lo, mon_e.lo);
        end
      end
    end
  end

  // Driver tasks; called at posedge+1.
  task automatic set_fwd(input logic [1:0] fa, input logic [1:0] fb, input logic src,
                         input logic [W-1:0] im, input logic [W-1:0] wbv, input logic [W-1:0] exv);
    forward_a = fa; forward_b = fb; alu_src = src;
    imm = im; wb_data = wbv; exmem_data = exv;
  endtask

  task automatic do_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp_res, input logic chk_hl,
                       input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input int exp_stall);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    alu_control = op; rs_data = a; rt_data = b; in_valid = 1'b1;
    exp_q.push_back('{res: exp_res, chk_hl: chk_hl, hi: exp_hi, lo: exp_lo});
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (stall) n++;
      else done = 1'b1;
    end
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: stall still high after %0d cycles, expected low", name, n);
    end
    check({name, "_stall_cycles"}, W'(n), W'(exp_stall));
    @(posedge clk); #1;
    in_valid = 1'b0;
    set_fwd(2'b00, 2'b00, 1'b0, '0, '0, '0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_result"}, result, '0);
    check({tag, "_zero"}, {31'b0, zero}, '0);
    check({tag, "_out_valid"}, {31'b0, out_valid}, '0);
    check({tag, "_hi"}, hi, '0);
    check({tag, "_lo"}, lo, '0);
    check({tag, "_stall"}, {31'b0, stall}, '0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Forwarding paths
    do_op("add", OP_ADD, 32'd7, 32'd5, 32'd12, 1'b0, '0, '0, 0);
    do_op("sub", OP_SUB, 32'd7, 32'd5, 32'd2, 1'b0, '0, '0, 0);
    set_fwd(2'b10, 2'b01, 1'b0, '0, 32'd9, 32'd9);
    do_op("sub_fwd", OP_SUB, 32'd7, 32'd5, 32'd0, 1'b0, '0, '0, 0);
    set_fwd(2'b11, 2'b00, 1'b0, '0, 32'd1000, 32'd100);
    do_op("add_fwd11", OP_ADD, 32'd7, 32'd5, 32'd12, 1'b0, '0, '0, 0);
    set_fwd(2'b00, 2'b00, 1'b1, 32'h10, '0, '0);
    do_op("add_imm", OP_ADD, 32'd7, 32'd5, 32'h17, 1'b0, '0, '0, 0);
    set_fwd(2'b00, 2'b10, 1'b1, 32'h10, '0, 32'd3);
    do_op("add_imm_fwd", OP_ADD, 32'd7, 32'd5, 32'd10, 1'b0, '0, '0, 0);

    // ALU functions
    do_op("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, '0, '0, 0);
    do_op("slt_false", OP_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, '0, '0, 0);
    do_op("sra", OP_SRA, 32'd4, 32'h8000_0000, 32'hF800_0000, 1'b0, '0, '0, 0);
    do_op("srl", OP_SRL, 32'd4, 32'h8000_0000, 32'h0800_0000, 1'b0, '0, '0, 0);
    do_op("sll", OP_SLL, 32'd36, 32'd1, 32'h10, 1'b0, '0, '0, 0);
    do_op("and", OP_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b0, '0, '0, 0);
    do_op("or",  OP_OR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 1'b0, '0, '0, 0);
    do_op("xor", OP_XOR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0, 1'b0, '0, '0, 0);
    do_op("nor", OP_NOR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h000F_F000, 1'b0, '0, '0, 0);
    do_op("sub_wrap", OP_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, '0, '0, 0);
    do_op("bad_code", OP_BAD, 32'd7, 32'd5, 32'd0, 1'b0, '0, '0, 0);

    // Multiply, then HI/LO reads
    hl_hi = 32'd1; hl_lo = 32'hFFFF_FFFE;
    do_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, hl_lo, 1'b1, hl_hi, hl_lo, 32);
    do_op("mfhi", OP_MFHI, '0, '0, hl_hi, 1'b0, '0, '0, 0);
    do_op("mflo", OP_MFLO, '0, '0, hl_lo, 1'b0, '0, '0, 0);

`ifdef EXU_DIV_EN
    do_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b1, 32'd2, 32'd14, 32);
    hl_hi = 32'd5; hl_lo = 32'hFFFF_FFFF;
    do_op("divu_zero", OP_DIVU, 32'd5, 32'd0, hl_lo, 1'b1, hl_hi, hl_lo, 32);
`else
    do_op("divu_off", OP_DIVU, 32'd100, 32'd7, 32'd0, 1'b1, hl_hi, hl_lo, 0);
`endif

    // Flush during RUN: no output, HI/LO keep prior values
    alu_control = OP_MULTU; rs_data = 32'd3; rt_data = 32'd5; in_valid = 1'b1;
    repeat (10) @(negedge clk);
    check("stall_before_flush", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("stall_after_flush", {31'b0, stall}, '0);
    check("flush_hi", hi, hl_hi);
    check("flush_lo", lo, hl_lo);
    repeat (40) @(posedge clk);
    #1;

    // Reset mid-RUN
    do_op("add_pre_rst", OP_ADD, 32'd7, 32'd5, 32'd12, 1'b0, '0, '0, 0);
    alu_control = OP_MULTU; rs_data = 32'd3; rt_data = 32'd5; in_valid = 1'b1;
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("rst_mid_run");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);

    @(negedge clk);
    check("exp_q_empty", W'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
